// File: rtl/pipelined_barrel_shifter.sv
// Two-stage pipelined barrel shifter (SLL/SRL/SRA, optional ROR) with valid/ready, tag and flush.
// Optional rotate path: define PIPELINED_SHIFTER_ROTATE_EN; otherwise op 11 behaves as SRL.
module pipelined_barrel_shifter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 5,
  localparam int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int unsigned L1 = (SHAMT_W + 1) / 2;
  localparam int unsigned L2 = SHAMT_W - L1;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b10;
`ifdef PIPELINED_SHIFTER_ROTATE_EN
  localparam logic [1:0] OP_ROR = 2'b11;
`endif

  function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] r;
    for (int unsigned i = 0; i < WIDTH; i++) r[i] = d[WIDTH-1-i];
    return r;
  endfunction

  // One mux level: shift right by 2^k, vacated MSBs take the fill bit or the wrapped bits.
  function automatic logic [WIDTH-1:0] shr_pow2(input logic [WIDTH-1:0] d,
                                                input int unsigned     k,
                                                input logic            fill,
                                                input logic            rot);
    logic [2*WIDTH-1:0] ext;
    ext = {(rot ? d : {WIDTH{fill}}), d};
    return WIDTH'(ext >> (32'd1 << k));
  endfunction

  logic               s1_valid;
  logic [WIDTH-1:0]   s1_data;
  logic [1:0]         s1_op;
  logic [L2-1:0]      s1_shamt_hi;
  logic               s1_fill;
  logic [TAG_W-1:0]   s1_tag;

  logic               s1_adv;
  logic               s2_adv;
  logic               in_rot;
  logic               s1_rot;
  logic               in_fill;
  logic [WIDTH-1:0]   s1_part;
  logic [WIDTH-1:0]   s2_part;
  logic [WIDTH-1:0]   s2_res;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

`ifdef PIPELINED_SHIFTER_ROTATE_EN
  assign in_rot = (in_op == OP_ROR);
  assign s1_rot = (s1_op == OP_ROR);
`else
  assign in_rot = 1'b0;
  assign s1_rot = 1'b0;
`endif

  assign in_fill = (in_op == OP_SRA) && in_data[WIDTH-1];

  // Stage 1: optional reversal for left shifts, then the low mux levels.
  always_comb begin
    s1_part = (in_op == OP_SLL) ? bit_rev(in_data) : in_data;
    for (int unsigned k = 0; k < L1; k++) begin
      if (in_shamt[k]) s1_part = shr_pow2(s1_part, k, in_fill, in_rot);
    end
  end

  // Stage 2: remaining mux levels, then undo the reversal for left shifts.
  always_comb begin
    s2_part = s1_data;
    for (int unsigned k = 0; k < L2; k++) begin
      if (s1_shamt_hi[k]) s2_part = shr_pow2(s2_part, L1 + k, s1_fill, s1_rot);
    end
    s2_res = (s1_op == OP_SLL) ? bit_rev(s2_part) : s2_part;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_data     <= '0;
      s1_op       <= '0;
      s1_shamt_hi <= '0;
      s1_fill     <= 1'b0;
      s1_tag      <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data     <= s1_part;
        s1_op       <= in_op;
        s1_shamt_hi <= in_shamt[SHAMT_W-1:L1];
        s1_fill     <= in_fill;
        s1_tag      <= in_tag;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= s2_res;
        out_tag  <= s1_tag;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Scoreboard bench for pipelined_barrel_shifter (WIDTH=32): directed, random, backpressure, flush, reset.
module tb_pipelined_barrel_shifter;

  localparam int unsigned W  = 32;
  localparam int unsigned TW = 5;
  localparam int unsigned SW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [SW-1:0] in_shamt;
  logic [1:0]    in_op;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [TW-1:0] out_tag;

  typedef struct {
    logic [W-1:0]  data;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  pipelined_barrel_shifter #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] d,
                                         input logic [SW-1:0] sh);
    int s;
    s = int'(sh);
    case (op)
      2'b00:   return d << s;
      2'b01:   return d >> s;
      2'b10:   return $signed(d) >>> s;
      default: begin
`ifdef PIPELINED_SHIFTER_ROTATE_EN
        if (s == 0) return d;
        return (d >> s) | (d << (32 - s));
`else
        return d >> s;
`endif
      end
    endcase
  endfunction

  task automatic drive(input logic [1:0] op, input logic [W-1:0] d, input logic [SW-1:0] sh,
                       input logic [TW-1:0] tag);
    in_valid = 1'b1;
    in_op    = op;
    in_data  = d;
    in_shamt = sh;
    in_tag   = tag;
  endtask

  // One clock: score the output consumed and the beat accepted on the coming edge.
  task automatic cycle();
    bit   acc;
    bit   con;
    exp_t e;
    #1;
    acc = in_valid && in_ready && !flush;
    con = out_valid && out_ready && !flush;
    if (con) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_out", 64'(out_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("sb_data", 64'(out_data), 64'(e.data));
        check_eq("sb_tag", 64'(out_tag), 64'(e.tag));
      end
    end
    if (flush) exp_q.delete();
    if (acc) begin
      e.data = model(in_op, in_data, in_shamt);
      e.tag  = in_tag;
      exp_q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8 && exp_q.size() > 0; i++) cycle();
    check_eq("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]    t_op [8];
    logic [W-1:0]  t_d  [8];
    logic [SW-1:0] t_sh [8];
    logic [W-1:0]  first;

    t_op = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b10};
    t_d  = '{32'h0000_0001, 32'h8000_0000, 32'hDEAD_BEEF, 32'hDEAD_BEEF,
             32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0001, 32'h7FFF_0000};
    t_sh = '{5'd31, 5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 5'd1, 5'd31};

    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_data = '0; in_shamt = '0; in_op = '0; in_tag = '0;
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_data", 64'(out_data), 64'd0);
    check_eq("rst_out_tag", 64'(out_tag), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Latency: SRA 0x8000_0000 by 4
    drive(2'b10, 32'h8000_0000, 5'd4, 5'd7);
    cycle();
    in_valid = 1'b0;
    check_eq("lat_e0_valid", 64'(out_valid), 64'd0);
    cycle();
    check_eq("lat_e1_valid", 64'(out_valid), 64'd1);
    check_eq("sra_data", 64'(out_data), 64'h0000_0000_F800_0000);
    check_eq("sra_tag", 64'(out_tag), 64'd7);
    drain();

    // Directed back-to-back at full throughput
    for (int i = 0; i < 8; i++) begin
      drive(t_op[i], t_d[i], t_sh[i], TW'(i + 1));
      #1 check_eq("thru_in_ready", 64'(in_ready), 64'd1);
      cycle();
      if (i == 6) begin
`ifdef PIPELINED_SHIFTER_ROTATE_EN
        check_eq("ror_const", 64'(exp_q[exp_q.size()-1].data), 64'h8000_0000);
`else
        check_eq("ror_const", 64'(exp_q[exp_q.size()-1].data), 64'h0);
`endif
      end
    end
    drain();

    // Random traffic with random backpressure
    for (int i = 0; i < 80; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_op     = 2'($urandom_range(0, 3));
      in_data   = $urandom;
      in_shamt  = SW'($urandom_range(0, 31));
      in_tag    = TW'($urandom_range(0, 31));
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    drain();

    // Backpressure: third beat must be refused, first result held
    out_ready = 1'b0;
    drive(2'b00, 32'h0000_00F1, 5'd8, 5'd11);
    cycle();
    drive(2'b01, 32'hF000_0000, 5'd12, 5'd12);
    cycle();
    drive(2'b10, 32'h9000_0000, 5'd3, 5'd13);
    #1;
    first = 32'h0000_F100;
    check_eq("bp_in_ready_low", 64'(in_ready), 64'd0);
    check_eq("bp_first_out", 64'(out_data), 64'(first));
    cycle();
    check_eq("bp_hold_data", 64'(out_data), 64'(first));
    check_eq("bp_hold_tag", 64'(out_tag), 64'd11);
    check_eq("bp_hold_valid", 64'(out_valid), 64'd1);
    check_eq("bp_still_full", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    #1 check_eq("bp_in_ready_rise", 64'(in_ready), 64'd1);
    cycle();
    drain();

    // Flush a full pipeline with a beat offered
    out_ready = 1'b0;
    drive(2'b00, 32'h1, 5'd1, 5'd21);
    cycle();
    drive(2'b00, 32'h1, 5'd2, 5'd22);
    cycle();
    drive(2'b00, 32'h1, 5'd3, 5'd23);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    check_eq("fl_out_valid", 64'(out_valid), 64'd0);
    check_eq("fl_s1_valid", 64'(dut.s1_valid), 64'd0);
    check_eq("fl_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check_eq("fl_no_ghost", 64'(out_valid), 64'd0);
    end

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    drive(2'b00, 32'h1, 5'd4, 5'd3);
    cycle();
    in_valid = 1'b0;
    cycle();
    check_eq("pre_rst_data", 64'(out_data), 64'h10);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_out_valid", 64'(out_valid), 64'd0);
    check_eq("arst_out_data", 64'(out_data), 64'd0);
    check_eq("arst_out_tag", 64'(out_tag), 64'd0);
    check_eq("arst_in_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(2'b01, 32'hABCD_0000, 5'd16, 5'd9);
    cycle();
    in_valid = 1'b0;
    check_eq("rrel_e0_valid", 64'(out_valid), 64'd0);
    cycle();
    check_eq("rrel_e1_valid", 64'(out_valid), 64'd1);
    check_eq("rrel_data", 64'(out_data), 64'h0000_ABCD);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipelined_barrel_shifter.md
# pipelined_barrel_shifter

Parametrised, two-stage pipelined barrel shifter for the RISC-V ALU datapath, successor to the combinational 32-bit left/right shifter. It supports logical left, logical right, arithmetic right and optional rotate-right on a configurable word width. It uses a valid/ready handshake with backpressure, a pass-through tag for writeback routing, and a synchronous flush. It sits between the decode/issue stage and the ALU result mux.

## Interface
- `WIDTH`, default 32: data width. Power of two, 8..64.
- `TAG_W`, default 5: width of the sideband tag (destination register index). Minimum 1.
- `SHAMT_W`, derived localparam, equals $clog2(WIDTH). Not overridable.
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `flush`, input, 1: synchronous pipeline kill.
- `in_valid`, input, 1: operand beat valid.
- `in_ready`, output, 1: block can accept a beat this cycle.
- `in_data`, input, WIDTH: operand A.
- `in_shamt`, input, SHAMT_W: shift amount.
- `in_op`, input, 2: operation. 00 SLL, 01 SRL, 10 SRA, 11 ROR.
- `in_tag`, input, TAG_W: sideband carried unchanged to the output.
- `out_valid`, output, 1: result valid.
- `out_ready`, input, 1: consumer accepts the result.
- `out_data`, output, WIDTH: shift result.
- `out_tag`, output, TAG_W: tag of the result.

## Operation
- Internal structure is log2(WIDTH) mux levels. Each level shifts by 2^k when `in_shamt[k]` is set.
- Left shifts are implemented by reversing the bits, shifting right, then reversing again.
- Fill bit rules:
  - SLL and SRL fill with 0.
  - SRA fills with `in_data[WIDTH-1]`.
  - ROR feeds the bits shifted out back into the vacated MSBs.
- Stage 1 (S1):
  - Performs the input bit-reversal and mux levels 0..ceil(SHAMT_W/2)-1.
  - Registers the partial result, op, shamt high bits, fill bit and tag.
  - Holds `s1_valid`.
- Stage 2 (S2):
  - Performs the remaining mux levels and the output bit-reversal.
  - Registers `out_data`, `out_tag` and `out_valid`.
- Shift amount 0 returns `in_data` unchanged for every op.
- Handshake:
  - S2 advances when `!out_valid || out_ready`.
  - S1 advances when `!s1_valid || S2 advances`.
  - `in_ready` = S1 advances (combinational from `out_ready` and state).
  - A beat is accepted on a rising edge with `in_valid && in_ready`.
- Backpressure: while `out_valid && !out_ready`, `out_data` and `out_tag` hold stable. At most 2 beats are in flight; the third beat sees `in_ready`=0.
- Flush: on an edge with `flush`=1, `s1_valid` and `out_valid` clear and any beat offered that cycle is dropped. Flush has priority over acceptance and over `out_ready`.
- Reset (asynchronous assert, release synchronised by the SoC reset block):
  - `out_valid`=0, `out_data`=0, `out_tag`=0.
  - `s1_valid`=0, all S1 data registers 0.
  - `in_ready` reads 1 during and after reset.
  - Reset asserted mid-operation discards all in-flight beats.

## Timing
- Latency: a beat accepted at edge E0 produces `out_valid`=1 immediately after edge E0+1, provided there was no stall.
- Throughput: one beat per cycle while `out_ready`=1.
- Same-edge events:
  - Output consumed and new beat accepted on the same edge: both occur, with no bubble.
  - Full pipeline with `out_ready` rising: `in_ready` rises in the same cycle.
- Combinational paths: only `out_ready` to `in_ready`. There is no path from `in_*` to `out_*`.
- Critical path: at most ceil(SHAMT_W/2)+1 mux levels per stage.

## Configuration
- `PIPELINED_SHIFTER_ROTATE_EN`
  - Defined: op 11 performs rotate-right by `in_shamt`.
  - Undefined: the rotate feedback path is not synthesised, and op 11 behaves exactly as SRL (01).

## Test plan
- WIDTH=32, SRA with `in_data`=0x8000_0000, shamt 4 -> `out_data`=0xF800_0000. `out_tag` equals `in_tag`. `out_valid` rises one edge after acceptance.
- SLL 0x0000_0001 by 31 -> 0x8000_0000. SRL 0x8000_0000 by 31 -> 0x0000_0001. Any op with shamt 0 on 0xDEAD_BEEF -> 0xDEAD_BEEF.
- ROR 0x0000_0001 by 1 -> 0x8000_0000 with the macro defined, 0x0000_0000 without it.
- Hold `out_ready`=0 and offer 3 back-to-back beats:
  - Only 2 are accepted; `in_ready` goes 0.
  - `out_data` holds the first result stable.
  - Releasing `out_ready` drains the results in order, with no loss or duplication.
- Pipeline full, assert `flush` while `in_valid`=1 -> next cycle `out_valid`=0, `s1_valid`=0, `in_ready`=1; the flushed beats never appear.
- Assert `rst_n`=0 mid-stream -> `out_valid`, `out_data` and `out_tag` go to 0 without waiting for a clock edge. After release, the first new beat has 2-edge latency.
